// File: rtl/vpu_cmd_queue.sv
// vpu_cmd_queue: DEPTH-entry command FIFO between CPU decode and the VPU.
// Decodes each VPU instruction at enqueue time, stores it with its operand
// snapshot, and issues one command at a time through a start/ready handshake.
// FILL commands issue as a one-cycle fill strobe without engaging the VPU.
//
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   stall           CPU pipeline stall, blocks enqueue only
//   cmd_valid       CPU presents an instruction this cycle
//   instr           16-bit VPU instruction word
//   obj_in          object number
//   vreg_in         NUM_VREG vector operands, V0 in the low DATA_W bits
//   ro_in           RO operand
//   vpu_rdy         VPU idle/ready level
//   cmd_ready       FIFO not full
//   count           FIFO occupancy
//   overflow        sticky: a command was dropped because the FIFO was full
//   busy            issue FSM not idle or FIFO non-empty
//   vpu_start       one-cycle VPU start pulse
//   vpu_fill        one-cycle fill pulse
//   vpu_op..ro_out  fields of the most recently issued command
module vpu_cmd_queue #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned NUM_VREG = 8,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned OBJ_W    = 5,
  parameter int unsigned CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         stall,
  input  logic                         cmd_valid,
  input  logic [15:0]                  instr,
  input  logic [OBJ_W-1:0]             obj_in,
  input  logic [NUM_VREG*DATA_W-1:0]   vreg_in,
  input  logic [DATA_W-1:0]            ro_in,
  input  logic                         vpu_rdy,
  output logic                         cmd_ready,
  output logic [CNT_W-1:0]             count,
  output logic                         overflow,
  output logic                         busy,
  output logic                         vpu_start,
  output logic                         vpu_fill,
  output logic [3:0]                   vpu_op,
  output logic [3:0]                   vpu_code,
  output logic [1:0]                   obj_type,
  output logic [2:0]                   obj_color,
  output logic [OBJ_W-1:0]             obj_num,
  output logic [NUM_VREG*DATA_W-1:0]   vreg_out,
  output logic [DATA_W-1:0]            ro_out
);

  localparam int unsigned VREG_W = NUM_VREG * DATA_W;
  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACK  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic              fill;
    logic [3:0]        op;
    logic [3:0]        code;
    logic [1:0]        otype;
    logic [2:0]        color;
    logic [OBJ_W-1:0]  obj;
    logic [VREG_W-1:0] vreg;
    logic [DATA_W-1:0] ro;
  } entry_t;

  entry_t           mem [DEPTH];
  entry_t           new_entry;
  entry_t           head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_d;
  logic             full;
  logic             empty;
  logic             push;
  logic             drop;
  logic             pop;
  logic             start_d;
  logic             fill_d;
  state_t           state_q;
  state_t           state_d;
  logic [3:0]       dec_op;
  logic [3:0]       dec_code;
  logic             dec_fill;

  // instr[8:4] carries no information for the queue
  logic unused_instr_bits;
  assign unused_instr_bits = ^instr[8:4];

  // Instruction decode, keyed on the opcode in instr[15:11]
  always_comb begin
    dec_op   = 4'h0;
    dec_fill = 1'b0;
    dec_code = {instr[1:0], instr[3:2]};
    case (instr[15:11])
      5'b10000, 5'b10001: dec_op = 4'h0;
      5'b10010: dec_fill = 1'b1;
      5'b10011: dec_op = instr[10] ? 4'h2 : 4'h1;
      5'b10100: dec_op = instr[10] ? 4'h4 : 4'h3;
      5'b10101: begin
        dec_op   = instr[10] ? 4'h6 : 4'h7;
        dec_code = instr[3:0];
      end
      5'b10110: begin
        dec_op   = 4'h5;
        dec_code = instr[3:0];
      end
      5'b10111: begin
        case (instr[1:0])
          2'd1:    dec_op = 4'h8;
          2'd2:    dec_op = 4'h9;
          default: dec_op = 4'hA;
        endcase
      end
      5'b11000: dec_op = instr[10] ? 4'hC : 4'hB;
      5'b11001: dec_op = 4'hF;
      default:  dec_op = 4'h0;
    endcase
  end

  always_comb begin
    new_entry.fill  = dec_fill;
    new_entry.op    = dec_op;
    new_entry.code  = dec_code;
    new_entry.otype = instr[10:9];
    new_entry.color = instr[2:0];
    new_entry.obj   = obj_in;
    new_entry.vreg  = vreg_in;
    new_entry.ro    = ro_in;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  // A full FIFO refuses the push even when the same cycle pops: no bypass
  assign push  = cmd_valid & ~stall & ~full;
  assign drop  = cmd_valid & ~stall & full;

  // Entry storage: payload only, needs no reset
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= new_entry;
  end

  always_comb begin
    case ({push, pop})
      2'b10:   count_d = count + CNT_W'(1);
      2'b01:   count_d = count - CNT_W'(1);
      default: count_d = count;
    endcase
  end

  // Pointers wrap modulo DEPTH, which is a power of two
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // Issue FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Issue FSM next state; FILL entries issue without leaving IDLE
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    start_d = 1'b0;
    fill_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty && vpu_rdy) begin
          pop = 1'b1;
          if (head.fill) begin
            fill_d = 1'b1;
          end else begin
            start_d = 1'b1;
            state_d = S_ACK;
          end
        end
      end
      S_ACK:   if (!vpu_rdy) state_d = S_DONE;
      S_DONE:  if (vpu_rdy)  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Registered status and issue outputs; fields hold until the next pop
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count     <= '0;
      cmd_ready <= 1'b1;
      overflow  <= 1'b0;
      busy      <= 1'b0;
      vpu_start <= 1'b0;
      vpu_fill  <= 1'b0;
      vpu_op    <= '0;
      vpu_code  <= '0;
      obj_type  <= '0;
      obj_color <= '0;
      obj_num   <= '0;
      vreg_out  <= '0;
      ro_out    <= '0;
    end else begin
      count     <= count_d;
      cmd_ready <= (count_d != CNT_W'(DEPTH));
      overflow  <= overflow | drop;
      busy      <= (state_d != S_IDLE) || (count_d != '0);
      vpu_start <= start_d;
      vpu_fill  <= fill_d;
      if (pop) begin
        vpu_op    <= head.op;
        vpu_code  <= head.code;
        obj_type  <= head.otype;
        obj_color <= head.color;
        obj_num   <= head.obj;
        vreg_out  <= head.vreg;
        ro_out    <= head.ro;
      end
    end
  end

endmodule

// File: tb/tb_vpu_cmd_queue.sv
// Self-checking bench for vpu_cmd_queue: directed scenario tasks with inline
// checks plus a scoreboard of expected issued commands compared on each pulse.
module tb_vpu_cmd_queue;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned NUM_VREG = 8;
  localparam int unsigned DEPTH    = 4;
  localparam int unsigned OBJ_W    = 5;
  localparam int unsigned CNT_W    = $clog2(DEPTH + 1);
  localparam int unsigned VW       = NUM_VREG * DATA_W;

  logic              clk;
  logic              rst_n;
  logic              stall;
  logic              cmd_valid;
  logic [15:0]       instr;
  logic [OBJ_W-1:0]  obj_in;
  logic [VW-1:0]     vreg_in;
  logic [DATA_W-1:0] ro_in;
  logic              vpu_rdy;
  logic              cmd_ready;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic              busy;
  logic              vpu_start;
  logic              vpu_fill;
  logic [3:0]        vpu_op;
  logic [3:0]        vpu_code;
  logic [1:0]        obj_type;
  logic [2:0]        obj_color;
  logic [OBJ_W-1:0]  obj_num;
  logic [VW-1:0]     vreg_out;
  logic [DATA_W-1:0] ro_out;

  vpu_cmd_queue #(
    .DATA_W(DATA_W), .NUM_VREG(NUM_VREG), .DEPTH(DEPTH), .OBJ_W(OBJ_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .cmd_valid(cmd_valid),
    .instr(instr), .obj_in(obj_in), .vreg_in(vreg_in), .ro_in(ro_in),
    .vpu_rdy(vpu_rdy), .cmd_ready(cmd_ready), .count(count), .overflow(overflow),
    .busy(busy), .vpu_start(vpu_start), .vpu_fill(vpu_fill), .vpu_op(vpu_op),
    .vpu_code(vpu_code), .obj_type(obj_type), .obj_color(obj_color),
    .obj_num(obj_num), .vreg_out(vreg_out), .ro_out(ro_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic              fill;
    logic [3:0]        op;
    logic [3:0]        code;
    logic [1:0]        typ;
    logic [2:0]        col;
    logic [OBJ_W-1:0]  obj;
    logic [VW-1:0]     vreg;
    logic [DATA_W-1:0] ro;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   passes = 0;

  // Reference decode of one instruction into its expected issued fields
  function automatic exp_t model(input logic [15:0] i, input logic [OBJ_W-1:0] o,
                                 input logic [VW-1:0] v, input logic [DATA_W-1:0] r);
    exp_t e;
    logic [4:0] opc;
    opc    = i[15:11];
    e.fill = (opc == 5'b10010);
    e.code = {i[1:0], i[3:2]};
    e.op   = 4'h0;
    if (opc == 5'b10011) e.op = i[10] ? 4'h2 : 4'h1;
    if (opc == 5'b10100) e.op = i[10] ? 4'h4 : 4'h3;
    if (opc == 5'b10101) begin e.op = i[10] ? 4'h6 : 4'h7; e.code = i[3:0]; end
    if (opc == 5'b10110) begin e.op = 4'h5; e.code = i[3:0]; end
    if (opc == 5'b10111) e.op = (i[1:0] == 2'd1) ? 4'h8 : (i[1:0] == 2'd2) ? 4'h9 : 4'hA;
    if (opc == 5'b11000) e.op = i[10] ? 4'hC : 4'hB;
    if (opc == 5'b11001) e.op = 4'hF;
    e.typ  = i[10:9];
    e.col  = i[2:0];
    e.obj  = o;
    e.vreg = v;
    e.ro   = r;
    return e;
  endfunction

  function automatic logic [VW-1:0] rand_vreg();
    logic [VW-1:0] v;
    for (int k = 0; k < int'(VW / 32); k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  // Scoreboard monitor: every start/fill pulse must match the oldest expectation
  always @(negedge clk) begin
    if (vpu_start || vpu_fill) begin
      checks++;
      if (vpu_start && vpu_fill) $display("FAIL both_pulses start=%b fill=%b exp not both", vpu_start, vpu_fill);
      else passes++;
      checks++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_pulse got op=%h obj=%h with nothing expected", vpu_op, obj_num);
      end else begin
        mon_e = sb.pop_front();
        if ({vpu_fill, vpu_op, vpu_code, obj_type, obj_color, obj_num, vreg_out, ro_out} !==
            {mon_e.fill, mon_e.op, mon_e.code, mon_e.typ, mon_e.col, mon_e.obj, mon_e.vreg, mon_e.ro})
          $display("FAIL issue_fields got fill=%b op=%h code=%h typ=%h col=%h obj=%h v=%h ro=%h exp fill=%b op=%h code=%h typ=%h col=%h obj=%h v=%h ro=%h",
                   vpu_fill, vpu_op, vpu_code, obj_type, obj_color, obj_num, vreg_out, ro_out,
                   mon_e.fill, mon_e.op, mon_e.code, mon_e.typ, mon_e.col, mon_e.obj, mon_e.vreg, mon_e.ro);
        else passes++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one command for one cycle; record it if it is expected to be accepted
  task automatic drive_cmd(input logic [15:0] i, input logic [OBJ_W-1:0] o,
                           input logic [VW-1:0] v, input logic [DATA_W-1:0] r, input bit exp_push);
    cmd_valid = 1'b1;
    instr     = i;
    obj_in    = o;
    vreg_in   = v;
    ro_in     = r;
    if (exp_push) sb.push_back(model(i, o, v, r));
    tick();
    cmd_valid = 1'b0;
  endtask

  // Act as the VPU for one issued command (bounded wait)
  task automatic serve_one(input string name);
    for (int n = 0; n < 40; n++) begin
      if (vpu_start) begin
        vpu_rdy = 1'b0;
        tick();
        vpu_rdy = 1'b1;
        tick();
        return;
      end
      if (vpu_fill) begin
        tick();
        return;
      end
      tick();
    end
    checks++;
    $display("FAIL %s_timeout got no pulse exp start or fill within 40 cycles", name);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = 1'b0; cmd_valid = 1'b1; instr = 16'h8005;
    obj_in = 5'd3; vreg_in = rand_vreg(); ro_in = 16'h5555; vpu_rdy = 1'b1;
    tick();
    tick();
    checks++; if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready got %b exp 1", cmd_ready); else passes++;
    checks++; if (count !== '0) $display("FAIL reset_count got %0d exp 0", count); else passes++;
    checks++; if (overflow !== 1'b0) $display("FAIL reset_overflow got %b exp 0", overflow); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else passes++;
    checks++; if ({vpu_start, vpu_fill} !== 2'b00) $display("FAIL reset_pulses got %b exp 00", {vpu_start, vpu_fill}); else passes++;
    checks++;
    if ({vpu_op, vpu_code, obj_type, obj_color, obj_num, ro_out} !== '0 || vreg_out !== '0)
      $display("FAIL reset_fields got op=%h code=%h obj=%h ro=%h exp all 0", vpu_op, vpu_code, obj_num, ro_out);
    else passes++;
    cmd_valid = 1'b0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_draw();
    logic [VW-1:0] v;
    v = rand_vreg();
    v[DATA_W-1:0] = 16'h1234;
    vpu_rdy = 1'b1;
    drive_cmd(16'h8005, 5'd3, v, 16'h00AB, 1'b1);
    checks++; if (vpu_start !== 1'b0) $display("FAIL draw_early_start got %b exp 0", vpu_start); else passes++;
    checks++; if (count !== CNT_W'(1)) $display("FAIL draw_count got %0d exp 1", count); else passes++;
    tick();
    checks++; if (vpu_start !== 1'b1) $display("FAIL draw_start got %b exp 1", vpu_start); else passes++;
    checks++; if (vpu_op !== 4'h0) $display("FAIL draw_op got %h exp 0", vpu_op); else passes++;
    checks++; if (obj_color !== 3'd5) $display("FAIL draw_color got %0d exp 5", obj_color); else passes++;
    checks++; if (obj_num !== 5'd3) $display("FAIL draw_obj got %0d exp 3", obj_num); else passes++;
    checks++; if (vreg_out[DATA_W-1:0] !== 16'h1234) $display("FAIL draw_v0 got %h exp 1234", vreg_out[DATA_W-1:0]); else passes++;
    vpu_rdy = 1'b0;
    tick();
    checks++; if (vpu_start !== 1'b0) $display("FAIL draw_start_width got %b exp 0", vpu_start); else passes++;
    tick();
    tick();
    checks++; if (busy !== 1'b1) $display("FAIL draw_busy_done got %b exp 1", busy); else passes++;
    vpu_rdy = 1'b1;
    tick();
    checks++; if (busy !== 1'b0) $display("FAIL draw_busy_idle got %b exp 0", busy); else passes++;
  endtask

  task automatic test_tran_rot();
    vpu_rdy = 1'b1;
    drive_cmd(16'hA40B, 5'd7, rand_vreg(), 16'h1111, 1'b1);
    drive_cmd(16'hA80D, 5'd9, rand_vreg(), 16'h2222, 1'b1);
    serve_one("tran");
    checks++; if ({vpu_op, vpu_code} !== 8'h4E) $display("FAIL tran_op_code got %h exp 4e", {vpu_op, vpu_code}); else passes++;
    serve_one("rot");
    checks++; if ({vpu_op, vpu_code} !== 8'h7D) $display("FAIL rot_op_code got %h exp 7d", {vpu_op, vpu_code}); else passes++;
  endtask

  task automatic test_fill_mat();
    vpu_rdy = 1'b1;
    drive_cmd(16'h9000, 5'd1, rand_vreg(), 16'h3333, 1'b1);
    drive_cmd(16'hC400, 5'd2, rand_vreg(), 16'h4444, 1'b1);
    checks++; if ({vpu_fill, vpu_start} !== 2'b10) $display("FAIL fill_pulse got fill,start=%b exp 10", {vpu_fill, vpu_start}); else passes++;
    tick();
    checks++; if ({vpu_fill, vpu_start} !== 2'b01) $display("FAIL mat_pulse got fill,start=%b exp 01", {vpu_fill, vpu_start}); else passes++;
    checks++; if (vpu_op !== 4'hC) $display("FAIL mat_op got %h exp c", vpu_op); else passes++;
    vpu_rdy = 1'b0;
    tick();
    vpu_rdy = 1'b1;
    tick();
  endtask

  task automatic test_overflow();
    vpu_rdy = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      drive_cmd(16'hA003, OBJ_W'(i + 1), rand_vreg(), DATA_W'(16'h0100 + i), i < 4);
      if (i == 3) begin
        checks++; if (cmd_ready !== 1'b0) $display("FAIL ovf_ready_full got %b exp 0", cmd_ready); else passes++;
        checks++; if (overflow !== 1'b0) $display("FAIL ovf_not_yet got %b exp 0", overflow); else passes++;
      end
    end
    checks++; if (count !== CNT_W'(4)) $display("FAIL ovf_count got %0d exp 4", count); else passes++;
    checks++; if (overflow !== 1'b1) $display("FAIL ovf_flag got %b exp 1", overflow); else passes++;
    // Push while full with a same-cycle pop must still be refused
    vpu_rdy = 1'b1;
    drive_cmd(16'hA003, 5'd30, rand_vreg(), 16'hDEAD, 1'b0);
    checks++; if (count !== CNT_W'(3)) $display("FAIL ovf_no_bypass got %0d exp 3", count); else passes++;
    for (int i = 0; i < 4; i++) serve_one("ovf_drain");
    checks++; if (count !== '0) $display("FAIL ovf_drained got %0d exp 0", count); else passes++;
    checks++; if (cmd_ready !== 1'b1) $display("FAIL ovf_ready_again got %b exp 1", cmd_ready); else passes++;
    checks++; if (overflow !== 1'b1) $display("FAIL ovf_sticky got %b exp 1", overflow); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL ovf_busy got %b exp 0", busy); else passes++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] tbl [12];
    tbl = '{16'h9C01, 16'h9806, 16'hA003, 16'hAC09, 16'hB007, 16'hB801,
            16'hB802, 16'hB803, 16'hC800, 16'hC000, 16'h8800, 16'h0F0F};
    tbl[5] = 16'hB801;
    for (int r = 0; r < 3; r++) begin
      vpu_rdy = 1'b0;
      for (int k = 0; k < 4; k++)
        drive_cmd(tbl[r*4 + k], OBJ_W'($urandom), rand_vreg(), DATA_W'($urandom), 1'b1);
      checks++; if (count !== CNT_W'(4)) $display("FAIL b2b_count round %0d got %0d exp 4", r, count); else passes++;
      vpu_rdy = 1'b1;
      for (int k = 0; k < 4; k++) serve_one("b2b");
    end
    // FILL opcode with instr[10] set still issues as a fill
    vpu_rdy = 1'b1;
    drive_cmd(16'h9400, 5'd4, rand_vreg(), 16'h7777, 1'b1);
    tick();
    checks++; if ({vpu_fill, vpu_start} !== 2'b10) $display("FAIL b2b_fill got fill,start=%b exp 10", {vpu_fill, vpu_start}); else passes++;
    tick();
  endtask

  task automatic test_stall_reset();
    vpu_rdy = 1'b0;
    drive_cmd(16'h8005, 5'd11, rand_vreg(), 16'hA0A0, 1'b1);
    stall = 1'b1;
    cmd_valid = 1'b1;
    instr = 16'hB007;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (count !== CNT_W'(1)) $display("FAIL stall_count cycle %0d got %0d exp 1", i, count); else passes++;
    end
    stall = 1'b0;
    cmd_valid = 1'b0;
    drive_cmd(16'hA003, 5'd12, rand_vreg(), 16'hB0B0, 1'b1);
    drive_cmd(16'hC000, 5'd13, rand_vreg(), 16'hC0C0, 1'b1);
    checks++; if (count !== CNT_W'(3)) $display("FAIL stall_count_after got %0d exp 3", count); else passes++;
    vpu_rdy = 1'b1;
    tick();
    checks++; if (vpu_start !== 1'b1) $display("FAIL stall_issue got %b exp 1", vpu_start); else passes++;
    vpu_rdy = 1'b0;
    tick();
    checks++; if (count !== CNT_W'(2) || busy !== 1'b1) $display("FAIL done_state got count=%0d busy=%b exp 2,1", count, busy); else passes++;
    rst_n = 1'b0;
    tick();
    sb.delete();
    tick();
    rst_n = 1'b1;
    vpu_rdy = 1'b1;
    tick();
    checks++; if (count !== '0) $display("FAIL midrst_count got %0d exp 0", count); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL midrst_busy got %b exp 0", busy); else passes++;
    checks++; if (overflow !== 1'b0) $display("FAIL midrst_overflow got %b exp 0", overflow); else passes++;
    checks++; if (cmd_ready !== 1'b1) $display("FAIL midrst_ready got %b exp 1", cmd_ready); else passes++;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (vpu_start !== 1'b0) $display("FAIL midrst_no_start cycle %0d got %b exp 0", i, vpu_start); else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_draw();
    test_tran_rot();
    test_fill_mat();
    test_overflow();
    test_back_to_back();
    test_stall_reset();
    checks++;
    if (sb.size() != 0) $display("FAIL sb_leftover got %0d pending exp 0", sb.size());
    else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/vpu_cmd_queue.md
Name: vpu_cmd_queue

Overview:
- Parametrised successor to the single-entry VPU command register between CPU decode and the VPU.
- Accepts decoded VPU instructions plus vector/RO operand snapshots from the CPU into a DEPTH-entry FIFO, so the CPU does not hold while the VPU is busy.
- An issue FSM presents one command at a time to the VPU using a start/ready handshake.
- FILL commands are issued as a one-cycle fill strobe without starting the VPU.

Parameters:
- DATA_W, 16: width of each vector/RO operand.
- NUM_VREG, 8: number of vector operands per command.
- DEPTH, 4: number of FIFO entries; must be a power of two and at least 2.
- OBJ_W, 5: object-number width.
- CNT_W, $clog2(DEPTH+1): occupancy counter width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- stall  in  1  CPU pipeline stall; blocks enqueue.
- cmd_valid  in  1  CPU presents a VPU instruction this cycle.
- instr  in  16  VPU instruction word.
- obj_in  in  OBJ_W  object number.
- vreg_in  in  NUM_VREG*DATA_W  vector operands; V0 is in bits [DATA_W-1:0].
- ro_in  in  DATA_W  RO operand.
- vpu_rdy  in  1  VPU idle/ready level.
- cmd_ready  out  1  FIFO not full.
- count  out  CNT_W  FIFO occupancy.
- overflow  out  1  sticky flag: a command was dropped.
- busy  out  1  FSM not IDLE, or FIFO non-empty.
- vpu_start  out  1  one-cycle start pulse.
- vpu_fill  out  1  one-cycle fill pulse.
- vpu_op  out  4  decoded op.
- vpu_code  out  4  decoded code.
- obj_type  out  2  instr[10:9].
- obj_color  out  3  instr[2:0].
- obj_num  out  OBJ_W  object number.
- vreg_out  out  NUM_VREG*DATA_W  issued vector operands.
- ro_out  out  DATA_W  issued RO operand.

Behaviour:
- Reset:
  - clk rising edge with rst_n=0 clears all outputs to 0, except cmd_ready=1.
  - FIFO pointers and count go to 0; FSM goes to IDLE; overflow is cleared.
  - Applies mid-operation; queued commands are discarded.
- Decode (combinational at enqueue; decoded fields are stored per entry), keyed on instr[15:11]:
  - Defaults: op=0, fill=0, code={instr[1:0],instr[3:2]}.
  - 10000 DRAW and 10001 ELLI: op=0.
  - 10010 FILL: fill=1.
  - 10011 RMV: op = instr[10] ? 2 : 1.
  - 10100 TRAN: op = instr[10] ? 4 : 3.
  - 10101 ROT: op = instr[10] ? 6 : 7; code=instr[3:0].
  - 10110 SCALE: op=5; code=instr[3:0].
  - 10111 REFLECT: op=8 if instr[1:0]=1, 9 if instr[1:0]=2, else A.
  - 11000 MAT: op = instr[10] ? C : B.
  - 11001 GETOBJ: op=F.
  - Any other opcode: defaults; still enqueued.
- Enqueue:
  - push = cmd_valid & ~stall & ~full.
  - cmd_valid & ~stall & full drops the command and sets overflow (sticky until reset).
  - A push while full is refused even if a pop occurs the same cycle; there is no bypass.
  - Simultaneous push and pop when not full leaves count unchanged.
  - stall=1 blocks enqueue only; issue continues.
- Issue FSM:
  - IDLE:
    - If FIFO non-empty and vpu_rdy=1: pop the head and register all output fields from it.
    - Entry with fill=1: pulse vpu_fill for one cycle; vpu_start stays 0; stay in IDLE, so the next entry may issue on the following cycle.
    - Entry with fill=0: pulse vpu_start for one cycle; go to ACK.
  - ACK: wait for vpu_rdy=0, then go to DONE.
  - DONE: wait for vpu_rdy=1, then go to IDLE.
  - Output fields hold their values until the next pop.
- Latency:
  - A push in cycle N, with vpu_rdy=1 and an empty queue, yields vpu_start/vpu_fill and valid outputs in cycle N+2.
  - vpu_start and vpu_fill are never both high.
- count: wraps neither direction; pointers wrap modulo DEPTH.

Test Plan:
- Reset: hold rst_n=0 for 2 clocks with cmd_valid=1 -> all outputs 0, cmd_ready=1, count=0, overflow=0, no pulses.
- DRAW: instr=16'h8005, obj_in=3, V0=16'h1234, vpu_rdy=1 -> vpu_start high exactly one cycle at push+2 with op=0, obj_color=5, obj_num=3, V0 out=16'h1234. Then drop vpu_rdy for 3 cycles and raise it -> FSM returns to IDLE and busy=0 one cycle later.
- TRAN: instr=16'hA40B -> vpu_op=4, vpu_code=4'hE. ROT: instr=16'hA80D -> vpu_op=7, vpu_code=4'hD.
- Overflow: vpu_rdy=0, DEPTH=4, 5 consecutive pushes -> count=4, cmd_ready=0, 5th command dropped, overflow=1. Then vpu_rdy=1 -> the 4 commands issue in order and the dropped one never appears.
- FILL then MAT: instr=16'h9000 followed by 16'hC400, vpu_rdy=1 -> vpu_fill pulse with vpu_start=0, then on the next cycle vpu_start with op=C.
- Stall and reset mid-operation: stall=1 with cmd_valid=1 for 3 cycles -> count unchanged. Reset asserted while in DONE with 2 entries queued -> count=0, FSM IDLE, no further starts after vpu_rdy rises.
